// File: rtl/full_adder_reg.sv
// Registered ripple-carry full adder: {cry,s} = a + b + ci, WIDTH bits wide.
// Latency: 1 cycle, inputs captured on the rising clk edge appear after that edge.
// Backpressure: none, the block samples every cycle. Reset clears outputs asynchronously.
module full_adder_reg #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic [WIDTH-1:0] s,
  output logic             cry
);

  // Carry chain: w_c[0] is the carry-in, w_c[WIDTH] the carry-out.
  logic [WIDTH:0]   w_c;
  logic [WIDTH-1:0] w_p;
  logic [WIDTH-1:0] w_sum;

  logic [WIDTH-1:0] r_s;
  logic             r_cry;

  // Bitwise ripple-carry: propagate = a^b, carry generated or propagated into the next bit.
  always_comb begin
    w_c    = '0;
    w_p    = '0;
    w_sum  = '0;
    w_c[0] = ci;
    for (int i = 0; i < WIDTH; i++) begin
      w_p[i]     = a[i] ^ b[i];
      w_sum[i]   = w_p[i] ^ w_c[i];
      w_c[i+1]   = (a[i] & b[i]) | (w_c[i] & w_p[i]);
    end
  end

  // Output register; reset discards any in-flight result immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s   <= '0;
      r_cry <= 1'b0;
    end else begin
      r_s   <= w_sum;
      r_cry <= w_c[WIDTH];
    end
  end

  assign s   = r_s;
  assign cry = r_cry;

endmodule

// File: tb/tb_full_adder_reg.sv
module tb_full_adder_reg;

  logic       clk;
  logic       rst_n;
  logic       a1, b1, ci1;
  logic       s1, cry1;
  logic [7:0] a8, b8;
  logic       ci8;
  logic [7:0] s8;
  logic       cry8;

  int pass_cnt;
  int total_cnt;

  full_adder_reg #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .ci(ci1), .s(s1), .cry(cry1)
  );

  full_adder_reg #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .ci(ci8), .s(s8), .cry(cry8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: the plain arithmetic sum, zero-extended to WIDTH+1 bits.
  function automatic logic [1:0] ref1(input logic a, input logic b, input logic c);
    ref1 = 2'(a) + 2'(b) + 2'(c);
  endfunction

  function automatic logic [8:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic c);
    ref8 = 9'(a) + 9'(b) + 9'(c);
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    a1 = 1'b1; b1 = 1'b1; ci1 = 1'b1;
    a8 = 8'hFF; b8 = 8'hFF; ci8 = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      total_cnt++;
      if ({cry1, s1} !== 2'b00) $display("FAIL reset_w1 cyc%0d got %b want 00", i, {cry1, s1});
      else pass_cnt++;
      total_cnt++;
      if ({cry8, s8} !== 9'h000) $display("FAIL reset_w8 cyc%0d got %h want 000", i, {cry8, s8});
      else pass_cnt++;
      a1 = ~a1; b1 = ~b1; ci1 = ~ci1;
      a8 = ~a8;
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_truth_table();
    logic [2:0]  v;
    logic [1:0]  exp;
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      @(negedge clk);
      {a1, b1, ci1} = v;
      exp = ref1(v[2], v[1], v[0]);
      @(posedge clk); #1;
      total_cnt++;
      if ({cry1, s1} !== exp) $display("FAIL truth_%b got %b want %b", v, {cry1, s1}, exp);
      else pass_cnt++;
    end
  endtask

  task automatic test_latency();
    @(negedge clk);
    a1 = 1'b1; b1 = 1'b0; ci1 = 1'b0;
    @(posedge clk); #1;
    total_cnt++;
    if (s1 !== 1'b1) $display("FAIL latency_after_N got %b want 1", s1);
    else pass_cnt++;
    a1 = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (s1 !== 1'b1) $display("FAIL latency_hold got %b want 1", s1);
    else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if (s1 !== 1'b0) $display("FAIL latency_after_N1 got %b want 0", s1);
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    a1 = 1'b1; b1 = 1'b1; ci1 = 1'b1;
    a8 = 8'hFF; b8 = 8'h01; ci8 = 1'b0;
    @(posedge clk); #1;
    total_cnt++;
    if ({cry1, s1} !== 2'b11) $display("FAIL async_pre got %b want 11", {cry1, s1});
    else pass_cnt++;
    #1;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({cry1, s1} !== 2'b00) $display("FAIL async_w1 got %b want 00", {cry1, s1});
    else pass_cnt++;
    total_cnt++;
    if ({cry8, s8} !== 9'h000) $display("FAIL async_w8 got %h want 000", {cry8, s8});
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_wrap8();
    logic [7:0] ta [3];
    logic [7:0] tb [3];
    logic       tc [3];
    logic [8:0] want [3];
    ta = '{8'hFF, 8'hFF, 8'h5A};
    tb = '{8'h00, 8'hFF, 8'h25};
    tc = '{1'b1, 1'b1, 1'b0};
    want = '{9'h100, 9'h1FF, 9'h07F};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a8 = ta[i]; b8 = tb[i]; ci8 = tc[i];
      @(posedge clk); #1;
      total_cnt++;
      if ({cry8, s8} !== want[i])
        $display("FAIL wrap8_%0d got %h want %h", i, {cry8, s8}, want[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_random();
    logic [1:0] e1;
    logic [8:0] e8;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      a1 = 1'($urandom); b1 = 1'($urandom); ci1 = 1'($urandom);
      a8 = 8'($urandom); b8 = 8'($urandom); ci8 = 1'($urandom);
      e1 = ref1(a1, b1, ci1);
      e8 = ref8(a8, b8, ci8);
      @(posedge clk); #1;
      // Disturb the inputs mid-cycle; outputs must not react before the next edge.
      a8 = ~a8; a1 = ~a1;
      #2;
      total_cnt++;
      if ({cry1, s1} !== e1) $display("FAIL rand_w1_%0d got %b want %b", i, {cry1, s1}, e1);
      else pass_cnt++;
      total_cnt++;
      if ({cry8, s8} !== e8) $display("FAIL rand_w8_%0d got %h want %h", i, {cry8, s8}, e8);
      else pass_cnt++;
      a8 = ~a8; a1 = ~a1;
      @(posedge clk);
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] q [$];
    logic [8:0] e8;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      a8 = 8'($urandom); b8 = 8'($urandom); ci8 = 1'($urandom);
      q.push_back(ref8(a8, b8, ci8));
      @(posedge clk); #1;
      e8 = q.pop_front();
      total_cnt++;
      if ({cry8, s8} !== e8) $display("FAIL b2b_%0d got %h want %h", i, {cry8, s8}, e8);
      else pass_cnt++;
    end
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst_n = 1'b1;
    a1 = 1'b0; b1 = 1'b0; ci1 = 1'b0;
    a8 = '0; b8 = '0; ci8 = 1'b0;
    test_reset();
    test_truth_table();
    test_latency();
    test_async_reset();
    test_wrap8();
    test_random();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
